qkv_projection: RTL and testbench

//   Upstream stage of attention: computes Q = X*Wq, K = X*Wk, V = X*Wv for one head by time-sharing
//   the 16x16 systolic array (SA_wrapper), three sequential matmuls. Captures each SA result and

---
 rtl/qkv_projection.sv | 166 ++++++++++++++++
 tb/tb_qkv_projection.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qkv_projection.sv
// Q/K/V projection for one attention head: three sequential matmuls (X*Wq, X*Wk, X*Wv)
// on a shared systolic array, results captured and presented with a valid/ack handshake.
module qkv_projection #(
  parameter int unsigned D_W     = 16,
  parameter int unsigned SA_R    = 16,
  parameter int unsigned SA_C    = 16,
  parameter int unsigned M_DIM   = 16,
  parameter int unsigned DIM     = 16,
  parameter int unsigned D_MODEL = 16,
  parameter int unsigned D_K     = 16
) (
  input  logic                         I_CLK,
  input  logic                         I_ASYN_RST,
  input  logic                         I_PROJ_START,
  input  logic [DIM*D_MODEL*D_W-1:0]   I_MAT_X,
  input  logic [D_MODEL*D_K*D_W-1:0]   I_W_Q,
  input  logic [D_MODEL*D_K*D_W-1:0]   I_W_K,
  input  logic [D_MODEL*D_K*D_W-1:0]   I_W_V,
  input  logic                         I_SA_VLD,
  input  logic [SA_R*SA_C*D_W-1:0]     I_SA_RESULT,
  input  logic                         I_QKV_ACK,
  output logic                         O_SA_START,
  output logic                         O_SA_CLEARN,
  output logic [SA_R*M_DIM*D_W-1:0]    O_MAT_1,
  output logic [M_DIM*SA_C*D_W-1:0]    O_MAT_2,
  output logic [DIM*D_K*D_W-1:0]       O_MAT_Q,
  output logic [DIM*D_K*D_W-1:0]       O_MAT_K,
  output logic [DIM*D_K*D_W-1:0]       O_MAT_V,
  output logic                         O_QKV_VLD,
  output logic                         O_BUSY
);

  localparam int unsigned MAT1_W = SA_R * M_DIM * D_W;
  localparam int unsigned MAT2_W = M_DIM * SA_C * D_W;
  localparam int unsigned OUT_W  = DIM * D_K * D_W;

  // The SA is used as-is, so the projection shape must match the array shape.
  if (D_MODEL != M_DIM || DIM != SA_R || D_K != SA_C) begin : g_dim_check
    $error("qkv_projection: D_MODEL/DIM/D_K must equal M_DIM/SA_R/SA_C");
  end

  typedef enum logic [7:0] {
    IDLE   = 8'b0000_0001,
    CLR_Q  = 8'b0000_0010,
    CALC_Q = 8'b0000_0100,
    CLR_K  = 8'b0000_1000,
    CALC_K = 8'b0001_0000,
    CLR_V  = 8'b0010_0000,
    CALC_V = 8'b0100_0000,
    DONE   = 8'b1000_0000
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                sa_start_nxt;
  logic                sa_clearn_nxt;
  logic                qkv_vld_nxt;
  logic                busy_nxt;
  logic [MAT1_W-1:0]   mat_1_nxt;
  logic [MAT2_W-1:0]   mat_2_nxt;
  logic [OUT_W-1:0]    mat_q_nxt;
  logic [OUT_W-1:0]    mat_k_nxt;
  logic [OUT_W-1:0]    mat_v_nxt;

  // State and all outputs registered; reset aborts any job in flight.
  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      state       <= IDLE;
      O_SA_START  <= 1'b0;
      O_SA_CLEARN <= 1'b1;
      O_MAT_1     <= '0;
      O_MAT_2     <= '0;
      O_MAT_Q     <= '0;
      O_MAT_K     <= '0;
      O_MAT_V     <= '0;
      O_QKV_VLD   <= 1'b0;
      O_BUSY      <= 1'b0;
    end else begin
      state       <= state_nxt;
      O_SA_START  <= sa_start_nxt;
      O_SA_CLEARN <= sa_clearn_nxt;
      O_MAT_1     <= mat_1_nxt;
      O_MAT_2     <= mat_2_nxt;
      O_MAT_Q     <= mat_q_nxt;
      O_MAT_K     <= mat_k_nxt;
      O_MAT_V     <= mat_v_nxt;
      O_QKV_VLD   <= qkv_vld_nxt;
      O_BUSY      <= busy_nxt;
    end
  end

  // Next-state and next-output logic; START and CLEARN default to inactive pulses.
  always_comb begin
    state_nxt     = state;
    sa_start_nxt  = 1'b0;
    sa_clearn_nxt = 1'b1;
    qkv_vld_nxt   = O_QKV_VLD;
    mat_1_nxt     = O_MAT_1;
    mat_2_nxt     = O_MAT_2;
    mat_q_nxt     = O_MAT_Q;
    mat_k_nxt     = O_MAT_K;
    mat_v_nxt     = O_MAT_V;

    unique case (state)
      IDLE: begin
        if (I_PROJ_START) begin
          state_nxt     = CLR_Q;
          mat_1_nxt     = MAT1_W'(I_MAT_X);
          mat_2_nxt     = MAT2_W'(I_W_Q);
          sa_clearn_nxt = 1'b0;
        end
      end
      CLR_Q: begin
        sa_start_nxt = 1'b1;
        state_nxt    = CALC_Q;
      end
      CALC_Q: begin
        if (I_SA_VLD) begin
          mat_q_nxt     = OUT_W'(I_SA_RESULT);
          mat_2_nxt     = MAT2_W'(I_W_K);
          sa_clearn_nxt = 1'b0;
          state_nxt     = CLR_K;
        end
      end
      CLR_K: begin
        sa_start_nxt = 1'b1;
        state_nxt    = CALC_K;
      end
      CALC_K: begin
        if (I_SA_VLD) begin
          mat_k_nxt     = OUT_W'(I_SA_RESULT);
          mat_2_nxt     = MAT2_W'(I_W_V);
          sa_clearn_nxt = 1'b0;
          state_nxt     = CLR_V;
        end
      end
      CLR_V: begin
        sa_start_nxt = 1'b1;
        state_nxt    = CALC_V;
      end
      CALC_V: begin
        // Last product: no further clear, the array is idle until the next job.
        if (I_SA_VLD) begin
          mat_v_nxt   = OUT_W'(I_SA_RESULT);
          qkv_vld_nxt = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        if (I_QKV_ACK) begin
          qkv_vld_nxt = 1'b0;
          mat_1_nxt   = '0;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        qkv_vld_nxt = 1'b0;
        mat_1_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_qkv_projection.sv
// Directed bench for qkv_projection with a behavioural 20-cycle systolic array model.
module tb_qkv_projection;

  localparam int unsigned N     = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned MW    = N * N * DW;
  localparam int          L_SA  = 20;
  localparam int          LAT   = 67;
  localparam int          LIMIT = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          proj_start;
  logic [MW-1:0] mat_x, w_q, w_k, w_v;
  logic          sa_vld;
  logic [MW-1:0] sa_result;
  logic          qkv_ack;
  logic          sa_start, sa_clearn, qkv_vld, busy;
  logic [MW-1:0] mat_1, mat_2, mat_q, mat_k, mat_v;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  qkv_projection dut (
    .I_CLK(clk), .I_ASYN_RST(rst), .I_PROJ_START(proj_start),
    .I_MAT_X(mat_x), .I_W_Q(w_q), .I_W_K(w_k), .I_W_V(w_v),
    .I_SA_VLD(sa_vld), .I_SA_RESULT(sa_result), .I_QKV_ACK(qkv_ack),
    .O_SA_START(sa_start), .O_SA_CLEARN(sa_clearn),
    .O_MAT_1(mat_1), .O_MAT_2(mat_2),
    .O_MAT_Q(mat_q), .O_MAT_K(mat_k), .O_MAT_V(mat_v),
    .O_QKV_VLD(qkv_vld), .O_BUSY(busy)
  );

  function automatic logic [MW-1:0] ramp();
    logic [MW-1:0] m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[(r*N+c)*DW +: DW] = 16'(r*37 + c*5 + 1);
    return m;
  endfunction

  function automatic logic [MW-1:0] diag(input logic [DW-1:0] d);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[(i*N+i)*DW +: DW] = d;
    return m;
  endfunction

  function automatic logic [MW-1:0] dbl(input logic [MW-1:0] a);
    logic [MW-1:0] m;
    for (int i = 0; i < N*N; i++) m[i*DW +: DW] = a[i*DW +: DW] << 1;
    return m;
  endfunction

  // Q4.11 product, truncated back to 16 bits.
  function automatic logic [MW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] m;
    int acc;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++)
          acc += int'($signed(a[(i*N+k)*DW +: DW])) * int'($signed(b[(k*N+j)*DW +: DW]));
        m[(i*N+j)*DW +: DW] = 16'(acc >>> 11);
      end
    return m;
  endfunction

  function automatic int fd(input logic [MW-1:0] a, input logic [MW-1:0] b);
    for (int i = 0; i < N*N; i++) if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
    return 0;
  endfunction

  // Systolic array model: VLD is high L_SA cycles after the START cycle.
  int            rem;
  logic          m_vld;
  logic [MW-1:0] m_res;
  logic          spur_vld;
  logic [MW-1:0] spur_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= 0;
      m_vld <= 1'b0;
      m_res <= '0;
    end else begin
      m_vld <= 1'b0;
      if (sa_start) begin
        rem   <= L_SA - 1;
        m_res <= matmul(mat_1, mat_2);
      end else if (rem != 0) begin
        rem <= rem - 1;
        if (rem == 1) m_vld <= 1'b1;
      end
    end
  end

  assign sa_vld    = m_vld | spur_vld;
  assign sa_result = spur_vld ? spur_res : m_res;

  // Monitor: START cycles, START rising edges, CLEARN-low cycles, W operand at each START.
  int            start_hi = 0, start_rise = 0, clr_lo = 0;
  logic          start_prev = 1'b0;
  logic [MW-1:0] w_log [16];

  always @(posedge clk) begin
    if (!rst) begin
      if (sa_start) begin
        w_log[4'(start_hi)] <= mat_2;
        start_hi <= start_hi + 1;
        if (!start_prev) start_rise <= start_rise + 1;
      end
      if (!sa_clearn) clr_lo <= clr_lo + 1;
      start_prev <= sa_start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(output int cyc);
    proj_start = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      proj_start = 1'b0;
    end while (!qkv_vld && cyc < LIMIT);
  endtask

  task automatic wait_vld(inout int cyc);
    while (!qkv_vld && cyc < LIMIT) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({sa_start, sa_clearn, qkv_vld, busy} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_ctrl: start/clearn/vld/busy got %b exp 0100", {sa_start, sa_clearn, qkv_vld, busy});
    end
    vectors++;
    if ({mat_1, mat_2, mat_q, mat_k, mat_v} !== '0) begin
      miscompares++;
      $display("FAIL reset_mats: matrix outputs not zero (mat_1[0]=%h mat_q[0]=%h)", mat_1[15:0], mat_q[15:0]);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    vectors++;
    if ({busy, qkv_vld, sa_clearn} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_idle: busy/vld/clearn got %b exp 001", {busy, qkv_vld, sa_clearn});
    end
  endtask

  task automatic test_identity();
    int cyc, s0, r0, c0;
    logic [MW-1:0] x;
    x = ramp();
    mat_x = x; w_q = diag(16'h0800); w_k = diag(16'h0800); w_v = diag(16'h0800);
    s0 = start_hi; r0 = start_rise; c0 = clr_lo;
    run_job(cyc);
    vectors++;
    if (cyc !== LAT) begin miscompares++; $display("FAIL id_latency: got %0d exp %0d", cyc, LAT); end
    vectors++;
    if (mat_q !== x) begin miscompares++; $display("FAIL id_q: elem %0d got %h exp %h", fd(mat_q, x), mat_q[fd(mat_q, x)*DW +: DW], x[fd(mat_q, x)*DW +: DW]); end
    vectors++;
    if (mat_k !== x) begin miscompares++; $display("FAIL id_k: elem %0d got %h exp %h", fd(mat_k, x), mat_k[fd(mat_k, x)*DW +: DW], x[fd(mat_k, x)*DW +: DW]); end
    vectors++;
    if (mat_v !== x) begin miscompares++; $display("FAIL id_v: elem %0d got %h exp %h", fd(mat_v, x), mat_v[fd(mat_v, x)*DW +: DW], x[fd(mat_v, x)*DW +: DW]); end
    vectors++;
    if (mat_1 !== x || busy !== 1'b1) begin miscompares++; $display("FAIL id_done_hold: mat_1 ok=%0b busy=%b exp 1/1", mat_1 === x, busy); end
    vectors++;
    if (start_hi - s0 !== 3 || start_rise - r0 !== 3 || clr_lo - c0 !== 3) begin
      miscompares++;
      $display("FAIL id_pulses: start cycles %0d rises %0d clearn-low %0d exp 3/3/3", start_hi - s0, start_rise - r0, clr_lo - c0);
    end
    qkv_ack = 1'b1;
    tick();
    qkv_ack = 1'b0;
    vectors++;
    if (qkv_vld !== 1'b0 || busy !== 1'b0 || mat_1 !== '0 || mat_q !== x) begin
      miscompares++;
      $display("FAIL id_ack: vld=%b busy=%b mat_1 zero=%0b q held=%0b exp 0/0/1/1", qkv_vld, busy, mat_1 === '0, mat_q === x);
    end
  endtask

  task automatic test_weight_seq();
    int cyc, s0, c0;
    logic [MW-1:0] x, wq, wk;
    x = ramp(); wq = diag(16'h0800); wk = diag(16'h1000);
    w_q = wq; w_k = wk; w_v = '0;
    s0 = start_hi; c0 = clr_lo;
    run_job(cyc);
    vectors++;
    if (w_log[4'(s0)] !== wq || w_log[4'(s0+1)] !== wk || w_log[4'(s0+2)] !== '0) begin
      miscompares++;
      $display("FAIL ws_mat2_seq: Wq ok=%0b Wk ok=%0b Wv ok=%0b exp 1/1/1", w_log[4'(s0)] === wq, w_log[4'(s0+1)] === wk, w_log[4'(s0+2)] === '0);
    end
    vectors++;
    if (start_hi - s0 !== 3 || clr_lo - c0 !== 3) begin
      miscompares++;
      $display("FAIL ws_pulses: start %0d clearn-low %0d exp 3/3", start_hi - s0, clr_lo - c0);
    end
    vectors++;
    if (mat_q !== x) begin miscompares++; $display("FAIL ws_q: elem %0d got %h exp %h", fd(mat_q, x), mat_q[fd(mat_q, x)*DW +: DW], x[fd(mat_q, x)*DW +: DW]); end
    vectors++;
    if (mat_k !== dbl(x)) begin miscompares++; $display("FAIL ws_k: elem %0d got %h exp %h", fd(mat_k, dbl(x)), mat_k[fd(mat_k, dbl(x))*DW +: DW], dbl(x) >> (fd(mat_k, dbl(x))*DW) & 16'hFFFF); end
    vectors++;
    if (mat_v !== '0) begin miscompares++; $display("FAIL ws_v: elem %0d got %h exp 0000", fd(mat_v, '0), mat_v[fd(mat_v, '0)*DW +: DW]); end
    qkv_ack = 1'b1;
    tick();
    qkv_ack = 1'b0;
  endtask

  task automatic test_spurious();
    int cyc;
    logic [MW-1:0] x;
    x = ramp();
    w_q = diag(16'h0800); w_k = diag(16'h0800); w_v = diag(16'h0800);
    spur_res = {256{16'hBEEF}};
    spur_vld = 1'b1;
    tick();
    spur_vld = 1'b0;
    vectors++;
    if (busy !== 1'b0 || qkv_vld !== 1'b0 || mat_q !== x || mat_k !== dbl(x) || mat_v !== '0) begin
      miscompares++;
      $display("FAIL sp_idle: busy=%b vld=%b q/k/v held=%0b exp 0/0/1", busy, qkv_vld, mat_q === x && mat_k === dbl(x) && mat_v === '0);
    end
    proj_start = 1'b1;
    tick();
    proj_start = 1'b0;
    cyc = 1;
    repeat (22) begin tick(); cyc++; end
    vectors++;
    if (sa_clearn !== 1'b0 || sa_start !== 1'b0) begin
      miscompares++;
      $display("FAIL sp_at_clr_k: clearn=%b start=%b exp 0/0", sa_clearn, sa_start);
    end
    spur_vld = 1'b1;
    tick();
    cyc++;
    spur_vld = 1'b0;
    vectors++;
    if (sa_start !== 1'b1 || mat_k !== dbl(x)) begin
      miscompares++;
      $display("FAIL sp_clr_k: start=%b k held=%0b exp 1/1", sa_start, mat_k === dbl(x));
    end
    wait_vld(cyc);
    vectors++;
    if (cyc !== LAT || mat_k !== x) begin
      miscompares++;
      $display("FAIL sp_finish: latency %0d k ok=%0b exp %0d/1", cyc, mat_k === x, LAT);
    end
    qkv_ack = 1'b1;
    tick();
    qkv_ack = 1'b0;
  endtask

  task automatic test_start_ignored();
    int cyc, s0;
    s0 = start_hi;
    proj_start = 1'b1;
    tick();
    proj_start = 1'b0;
    cyc = 1;
    repeat (29) begin tick(); cyc++; end
    proj_start = 1'b1;
    tick();
    cyc++;
    proj_start = 1'b0;
    wait_vld(cyc);
    vectors++;
    if (cyc !== LAT) begin miscompares++; $display("FAIL si_latency: got %0d exp %0d", cyc, LAT); end
    proj_start = 1'b1;
    qkv_ack = 1'b1;
    tick();
    proj_start = 1'b0;
    qkv_ack = 1'b0;
    vectors++;
    if (qkv_vld !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL si_ack_start: vld=%b busy=%b exp 0/0", qkv_vld, busy);
    end
    repeat (2) tick();
    vectors++;
    if (busy !== 1'b0 || sa_clearn !== 1'b1 || start_hi - s0 !== 3) begin
      miscompares++;
      $display("FAIL si_no_restart: busy=%b clearn=%b starts=%0d exp 0/1/3", busy, sa_clearn, start_hi - s0);
    end
  endtask

  task automatic test_done_hold();
    int cyc;
    logic [MW-1:0] x;
    x = ramp();
    qkv_ack = 1'b1;
    tick();
    qkv_ack = 1'b0;
    vectors++;
    if (busy !== 1'b0 || qkv_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL dh_ack_idle: busy=%b vld=%b exp 0/0", busy, qkv_vld);
    end
    w_q = diag(16'h0800); w_k = diag(16'h1000); w_v = diag(16'h0800);
    run_job(cyc);
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (qkv_vld !== 1'b1 || busy !== 1'b1 || mat_q !== x || mat_k !== dbl(x) || mat_v !== x || mat_1 !== x) begin
        miscompares++;
        $display("FAIL dh_stable: cycle %0d vld=%b busy=%b q/k/v/mat_1 ok=%0b exp 1/1/1", i, qkv_vld, busy,
                 mat_q === x && mat_k === dbl(x) && mat_v === x && mat_1 === x);
      end
    end
    qkv_ack = 1'b1;
    tick();
    qkv_ack = 1'b0;
    vectors++;
    if (qkv_vld !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL dh_release: vld=%b busy=%b exp 0/0", qkv_vld, busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, s0;
    logic [MW-1:0] x;
    x = ramp();
    w_q = diag(16'h0800); w_k = diag(16'h0800); w_v = diag(16'h0800);
    proj_start = 1'b1;
    tick();
    proj_start = 1'b0;
    repeat (49) tick();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({sa_start, sa_clearn, qkv_vld, busy} !== 4'b0100 || {mat_1, mat_2, mat_q, mat_k, mat_v} !== '0) begin
      miscompares++;
      $display("FAIL rm_async: start/clearn/vld/busy got %b exp 0100, mats zero=%0b exp 1",
               {sa_start, sa_clearn, qkv_vld, busy}, {mat_1, mat_2, mat_q, mat_k, mat_v} === '0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    s0 = start_hi;
    run_job(cyc);
    vectors++;
    if (cyc !== LAT || mat_q !== x || mat_k !== x || mat_v !== x || start_hi - s0 !== 3) begin
      miscompares++;
      $display("FAIL rm_rerun: latency %0d q/k/v ok=%0b starts %0d exp %0d/1/3", cyc,
               mat_q === x && mat_k === x && mat_v === x, start_hi - s0, LAT);
    end
    qkv_ack = 1'b1;
    tick();
    qkv_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    proj_start = 1'b0;
    qkv_ack = 1'b0;
    spur_vld = 1'b0;
    spur_res = '0;
    mat_x = '0; w_q = '0; w_k = '0; w_v = '0;
    test_reset();
    test_identity();
    test_weight_seq();
    test_spurious();
    test_start_ignored();
    test_done_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish exp finish");
    $fatal(1, "watchdog");
  end

endmodule
